// File: rtl/share_pkg.sv
// Shared constants for the share decoder: default geometry and delivered-word counter width.
package share_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 2;
  localparam int CNT_W     = 16;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/share_fifo.sv
// Registered DEPTH-entry buffer with occupancy count; head entry drives the output directly.
// SHARE_DECODER_ZEROIZE_EN clears an entry to zero as it is popped.
module share_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop    = pop && (count_q != '0);
  assign do_push   = push && ((count_q != FULL) || do_pop);
  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_pop) begin
`ifdef SHARE_DECODER_ZEROIZE_EN
      mem_d[rd_ptr_q] = '0;
`endif
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    // Push after the pop clear so a full-buffer push/pop into the same slot keeps the new word.
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/share_decoder.sv
// Two-share unmasking stage: shares registered separately, XORed into a small output buffer.
// SHARE_DECODER_ZEROIZE_EN clears stage-1 shares once they move on without a new accept.
module share_decoder
  import share_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] s0,
  input  logic [WIDTH-1:0] s1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [WIDTH-1:0] s0_q, s0_d;
  logic [WIDTH-1:0] s1_q, s1_d;
  logic             st1_vld_q, st1_vld_d;
  logic             rdy_en_q, rdy_en_d;
  cnt_t             word_cnt_q, word_cnt_d;
  logic [CW-1:0]    occ;
  logic [CW:0]      used;
  logic             accept, pop;

  // Stage 1 always drains next edge, so reserving its slot here guarantees the push has room.
  assign used      = {1'b0, occ} + {{CW{1'b0}}, st1_vld_q};
  assign in_ready  = rdy_en_q && (used < DEPTH_W);
  assign accept    = in_valid && in_ready;
  assign out_valid = (occ != '0);
  assign pop       = out_valid && out_ready;
  assign word_cnt  = word_cnt_q;

  always_comb begin
    s0_d       = s0_q;
    s1_d       = s1_q;
    st1_vld_d  = accept;
    rdy_en_d   = 1'b1;
    word_cnt_d = word_cnt_q + cnt_t'(pop);
`ifdef SHARE_DECODER_ZEROIZE_EN
    if (st1_vld_q && !accept) begin
      s0_d = '0;
      s1_d = '0;
    end
`endif
    if (accept) begin
      s0_d = s0;
      s1_d = s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q       <= '0;
      s1_q       <= '0;
      st1_vld_q  <= 1'b0;
      rdy_en_q   <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      st1_vld_q  <= st1_vld_d;
      rdy_en_q   <= rdy_en_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  share_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (st1_vld_q),
    .push_data(s0_q ^ s1_q),
    .pop      (pop),
    .head_data(out_data),
    .count    (occ)
  );

endmodule

// File: tb/tb_share_decoder.sv
// Directed bench for share_decoder: XOR vector table plus backpressure, reset, streaming and wrap sequences.
module tb_share_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] s0, s1, out_data;
  logic [15:0] word_cnt;

  logic       rst4_n, in_valid4, in_ready4, out_valid4, out_ready4;
  logic [7:0] s04, s14, out_data4;
  logic [15:0] word_cnt4;

  share_decoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .s0(s0), .s1(s1), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .word_cnt(word_cnt)
  );

  // Full-rate streaming needs buffer headroom beyond the word held on the output.
  share_decoder #(.WIDTH(8), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .s0(s04), .s1(s14), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_data(out_data4), .word_cnt(word_cnt4)
  );

  typedef struct {
    logic [7:0] s0;
    logic [7:0] s1;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [7];
  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [7:0] a, input logic [7:0] b, input logic [7:0] e);
    int n;
    s0 = a;
    s1 = b;
    in_valid = 1'b1;
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("latency_n1_valid", out_valid, 0);
    tick();
    check("latency_n2_valid", out_valid, 1);
    check("xor_data", out_data, e);
    tick();
    exp_cnt++;
    check("word_cnt", word_cnt, exp_cnt);
    check("drained", out_valid, 0);
  endtask

  task automatic check_zeroize();
`ifdef SHARE_DECODER_ZEROIZE_EN
    check("zero_s0_q", dut.s0_q, 8'h00);
    check("zero_s1_q", dut.s1_q, 8'h00);
    check("zero_mem0", dut.u_fifo.mem_q[0], 8'h00);
    check("zero_mem1", dut.u_fifo.mem_q[1], 8'h00);
`else
    check("stale_s0_q", dut.s0_q, 8'hFF);
    check("stale_s1_q", dut.s1_q, 8'h0F);
    check("stale_mem0", dut.u_fifo.mem_q[0], 8'h99);
    check("stale_mem1", dut.u_fifo.mem_q[1], 8'hF0);
`endif
  endtask

  initial begin
    logic [7:0] bp_exp [3];
    logic [7:0] sx [10];
    logic [7:0] sy [10];
    logic [7:0] ex [10];
    int idx, got, k, last, hs, n;
    bit acc, pop4;

    vecs[0] = '{8'hA5, 8'h3C, 8'h99};
    vecs[1] = '{8'hFF, 8'h0F, 8'hF0};
    vecs[2] = '{8'h00, 8'h00, 8'h00};
    vecs[3] = '{8'hFF, 8'hFF, 8'h00};
    vecs[4] = '{8'h55, 8'hAA, 8'hFF};
    vecs[5] = '{8'h80, 8'h01, 8'h81};
    vecs[6] = '{8'h12, 8'h34, 8'h26};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; s0 = '0; s1 = '0;
    rst4_n = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0; s04 = '0; s14 = '0;

    // Reset state
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_out_data", out_data, 0);
    tick();
    tick();
    check("rst_hold_in_ready", in_ready, 0);
    rst_n = 1'b1;
    rst4_n = 1'b1;
    check("rel_in_ready_pre_edge", in_ready, 0);
    tick();
    check("rel_in_ready_edge1", in_ready, 1);

    // XOR vector table
    for (int i = 0; i < 7; i++) begin
      send_one(vecs[i].s0, vecs[i].s1, vecs[i].exp);
      if (i == 1) check_zeroize();
    end

    // Backpressure: two accepts fill the buffer plus stage 1, head word held
    bp_exp[0] = 8'h01; bp_exp[1] = 8'h02; bp_exp[2] = 8'h03;
    out_ready = 1'b0;
    s0 = 8'h01; s1 = 8'h00; in_valid = 1'b1;
    check("bp_ready1", in_ready, 1);
    tick();
    check("bp_ready2", in_ready, 1);
    s0 = 8'h02;
    tick();
    check("bp_drop", in_ready, 0);
    check("bp_head", out_data, 8'h01);
    s0 = 8'h03;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("bp_hold_ready", in_ready, 0);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_data", out_data, 8'h01);
    end
    out_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 10 && idx < 3; c++) begin
      acc = in_valid && in_ready;
      if (out_valid) begin
        check("bp_order", out_data, bp_exp[idx]);
        idx++;
      end
      tick();
      if (acc) in_valid = 1'b0;
    end
    check("bp_count", idx, 3);
    exp_cnt += 3;
    check("bp_word_cnt", word_cnt, exp_cnt);

    // Reset mid-stream: one word buffered, one in stage 1
    out_ready = 1'b0;
    s0 = 8'h11; s1 = 8'h22; in_valid = 1'b1;
    tick();
    s0 = 8'h33;
    tick();
    check("mid_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_cnt", word_cnt, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_ready", in_ready, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("mid_rel_ready", in_ready, 1);
    for (int c = 0; c < 4; c++) begin
      check("mid_no_output", out_valid, 0);
      tick();
    end

    // Streaming at full rate on the deeper instance
    for (int i = 0; i < 10; i++) begin
      sx[i] = 8'(i * 37 + 5);
      sy[i] = 8'(i * 11 + 8'h60);
      ex[i] = sx[i] ^ sy[i];
    end
    out_ready4 = 1'b1;
    s04 = sx[0]; s14 = sy[0]; in_valid4 = 1'b1;
    got = 0; k = 0; last = -1;
    for (int c = 0; c < 40 && got < 10; c++) begin
      acc = in_valid4 && in_ready4;
      if (out_valid4) begin
        check("stream_data", out_data4, ex[got]);
        if (got > 0) check("stream_gap", c, last + 1);
        last = c;
        got++;
      end
      tick();
      if (acc) begin
        k++;
        if (k < 10) begin
          s04 = sx[k];
          s14 = sy[k];
        end else begin
          in_valid4 = 1'b0;
        end
      end
    end
    check("stream_count", got, 10);
    check("stream_word_cnt", word_cnt4, 10);

    // Counter wrap: continue streaming to 65535 deliveries, then one more
    hs = 10;
    s04 = 8'h5A; s14 = 8'h0F; in_valid4 = 1'b1;
    for (int c = 0; c < 70000 && hs < 65535; c++) begin
      pop4 = out_valid4 && out_ready4;
      tick();
      if (pop4) hs++;
    end
    out_ready4 = 1'b0;
    check("wrap_pre", word_cnt4, 16'hFFFF);
    n = 0;
    while (!out_valid4 && n < 10) begin
      tick();
      n++;
    end
    check("wrap_word_avail", out_valid4, 1);
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    in_valid4 = 1'b0;
    check("wrap_zero", word_cnt4, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
